// File: rtl/riscv_dbg_pkg.sv
// Shared encodings and helpers for the register-file probe monitor.
// Counter and register-index widths live here so every file agrees on them.
package riscv_dbg_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_RUN     = 2'd1,
    MON_HALTED  = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rf_probe_monitor_if.sv
// Write-back snoop bus: the core (master) drives it, the monitor (slave) listens.
interface rf_probe_monitor_if
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN = 32
);

  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 retire_valid;

  modport master (output wb_we, output wb_rd, output wb_data, output retire_valid);
  modport slave  (input  wb_we, input  wb_rd, input  wb_data, input  retire_valid);

endinterface

// File: rtl/probe_slot.sv
// One shadow register: captures write-back data aimed at REG_IDX while enabled,
// and remembers that it has been written since the last reset/clear.
module probe_slot
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 cap_en,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      value,
  output logic                 written
);

  localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(REG_IDX);

  logic            hit;
  logic [XLEN-1:0] value_d, value_q;
  logic            written_d, written_q;

  always_comb begin
    // x0 is never shadowed even if the window happens to start at 0.
    hit       = cap_en && wb_we && (wb_rd == IDX) && (wb_rd != '0);
    value_d   = value_q;
    written_d = written_q;
    if (clr) begin
      value_d   = '0;
      written_d = 1'b0;
    end else if (hit) begin
      value_d   = wb_data;
      written_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q   <= '0;
      written_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      written_q <= written_d;
    end
  end

  assign value   = value_q;
  assign written = written_q;

endmodule

// File: rtl/rf_probe_monitor.sv
// Register-file probe monitor: shadows a window of architectural registers and
// flags program completion (retire idle) or runaway (cycle timeout).
module rf_probe_monitor
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_PROBE      = 6,
  parameter int PROBE_BASE     = 1,
  parameter int IDLE_LIMIT     = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  rf_probe_monitor_if.slave         wb,
  output logic [NUM_PROBE*XLEN-1:0] probe_regs,
  output logic [NUM_PROBE-1:0]      probe_written,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          retire_count,
  output logic [1:0]                mon_state,
  output logic                      done,
  output logic                      timeout
);

  localparam int                IDLE_W   = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);
  localparam logic [CNT_W-1:0]  TO_CNT   = CNT_W'(TIMEOUT_CYCLES);

  mon_state_e        state_d, state_q;
  logic [CNT_W-1:0]  cycle_d, cycle_q;
  logic [CNT_W-1:0]  retire_d, retire_q;
  logic [IDLE_W-1:0] idle_d, idle_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;
  logic              cap_en;

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    idle_d   = idle_q;
    if (clr) begin
      state_d  = MON_IDLE;
      cycle_d  = '0;
      retire_d = '0;
      idle_d   = '0;
    end else begin
      case (state_q)
        MON_IDLE: begin
          // The first retiring cycle is already cycle 1 of the run.
          if (wb.retire_valid) begin
            state_d  = MON_RUN;
            cycle_d  = CNT_W'(1);
            retire_d = CNT_W'(1);
            idle_d   = '0;
          end
        end
        MON_RUN: begin
          cycle_d = sat_inc(cycle_q);
          if (wb.retire_valid) begin
            retire_d = sat_inc(retire_q);
            idle_d   = '0;
          end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
          end
          // Timeout is checked first so it wins a same-cycle tie with halt.
          if (cycle_d == TO_CNT) begin
            state_d = MON_TIMEOUT;
          end else if (idle_d == IDLE_MAX) begin
            state_d = MON_HALTED;
          end
        end
        default: ;
      endcase
    end
    done_d    = (state_d == MON_HALTED);
    timeout_d = (state_d == MON_TIMEOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MON_IDLE;
      cycle_q   <= '0;
      retire_q  <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Shadows freeze once a terminal state is reached, keeping a final snapshot.
  assign cap_en = (state_q == MON_IDLE) || (state_q == MON_RUN);

  for (genvar gi = 0; gi < NUM_PROBE; gi++) begin : g_slot
    probe_slot #(
      .XLEN    (XLEN),
      .REG_IDX (PROBE_BASE + gi)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .cap_en  (cap_en),
      .wb_we   (wb.wb_we),
      .wb_rd   (wb.wb_rd),
      .wb_data (wb.wb_data),
      .value   (probe_regs[gi*XLEN +: XLEN]),
      .written (probe_written[gi])
    );
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign mon_state    = state_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_rf_probe_monitor.sv
// Directed bench for rf_probe_monitor: four instances with different parameters
// share one write-back bus; only the instance under test is out of reset.
module tb_rf_probe_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b0;
  logic rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0, rst_n3 = 1'b0;

  rf_probe_monitor_if #(.XLEN(32)) bus ();

  logic [191:0] pr0, pr1, pr2;
  logic [127:0] pr3;
  logic [5:0]   pw0, pw1, pw2;
  logic [3:0]   pw3;
  logic [31:0]  cc0, cc1, cc2, cc3, rc0, rc1, rc2, rc3;
  logic [1:0]   st0, st1, st2, st3;
  logic         dn0, dn1, dn2, dn3, to0, to1, to2, to3;

  rf_probe_monitor u_dut0 (
    .clk(clk), .reset(rst_n0), .clr(clr), .wb(bus),
    .probe_regs(pr0), .probe_written(pw0), .cycle_count(cc0), .retire_count(rc0),
    .mon_state(st0), .done(dn0), .timeout(to0));

  rf_probe_monitor #(.TIMEOUT_CYCLES(50)) u_dut1 (
    .clk(clk), .reset(rst_n1), .clr(clr), .wb(bus),
    .probe_regs(pr1), .probe_written(pw1), .cycle_count(cc1), .retire_count(rc1),
    .mon_state(st1), .done(dn1), .timeout(to1));

  rf_probe_monitor #(.IDLE_LIMIT(4), .TIMEOUT_CYCLES(10)) u_dut2 (
    .clk(clk), .reset(rst_n2), .clr(clr), .wb(bus),
    .probe_regs(pr2), .probe_written(pw2), .cycle_count(cc2), .retire_count(rc2),
    .mon_state(st2), .done(dn2), .timeout(to2));

  rf_probe_monitor #(.NUM_PROBE(4), .PROBE_BASE(10)) u_dut3 (
    .clk(clk), .reset(rst_n3), .clr(clr), .wb(bus),
    .probe_regs(pr3), .probe_written(pw3), .cycle_count(cc3), .retire_count(rc3),
    .mon_state(st3), .done(dn3), .timeout(to3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one bus cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input logic rv);
    bus.wb_we        = we;
    bus.wb_rd        = rd;
    bus.wb_data      = data;
    bus.retire_valid = rv;
    @(posedge clk);
    #1;
  endtask

  int n_ret;
  int waited;

  initial begin
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.retire_valid = 1'b0;
    #22;
    check("rst_state", 64'(st0), 64'd0);
    check("rst_regs_lo", pr0[63:0], 64'd0);
    check("rst_counts", {cc0, rc0}, 64'd0);
    check("rst_flags", {58'd0, pw0}, 64'd0);
    check("rst_done_to", {62'd0, dn0, to0}, 64'd0);

    // ---- window capture (defaults) ----
    rst_n0 = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b1);
    check("first_state", 64'(st0), 64'd1);
    check("first_counts", {cc0, rc0}, {32'd1, 32'd1});
    step(1'b1, 5'd3, 32'h0000_00AA, 1'b1);
    check("cap_slot2", 64'(pr0[95:64]), 64'h0000_00AA);
    check("cap_written", 64'(pw0), 64'b000100);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 5'd9, 32'h5555_5555, 1'b1);
    check("ignore_lo", pr0[63:0], 64'd0);
    check("ignore_mid", pr0[127:64], 64'h0000_0000_0000_00AA);
    check("ignore_hi", pr0[191:128], 64'd0);
    check("ignore_written", 64'(pw0), 64'b000100);
    step(1'b1, 5'd4, 32'h0000_0001, 1'b1);
    check("b2b_first", 64'(pr0[127:96]), 64'd1);
    step(1'b1, 5'd4, 32'h0000_0002, 1'b1);
    check("b2b_second", 64'(pr0[127:96]), 64'd2);
    n_ret = 6;

    // ---- idle halt ----
    while (n_ret < 20) begin
      step(1'b0, 5'd0, 32'h0, 1'b1);
      n_ret++;
    end
    check("pre_halt_retire", 64'(rc0), 64'd20);
    waited = 0;
    while (waited < 40 && dn0 !== 1'b1) begin
      step(1'b0, 5'd0, 32'h0, 1'b0);
      waited++;
    end
    check("halt_latency", 64'(waited), 64'd16);
    check("halt_state", 64'(st0), 64'd2);
    check("halt_counts", {cc0, rc0}, {32'd36, 32'd20});
    check("halt_to", 64'(to0), 64'd0);
    step(1'b1, 5'd1, 32'h0000_1234, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b0);
    check("frozen_slot0", 64'(pr0[31:0]), 64'd0);
    check("frozen_written", 64'(pw0), 64'b001100);
    check("frozen_counts", {cc0, rc0}, {32'd36, 32'd20});

    // ---- clr from a terminal state ----
    clr = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b1);
    clr = 1'b0;
    check("clr_state", {60'd0, st0, dn0, to0}, 64'd0);
    check("clr_counts", {cc0, rc0}, 64'd0);
    check("clr_regs", pr0[127:64], 64'd0);
    check("clr_written", 64'(pw0), 64'd0);

    // ---- asynchronous reset mid-run ----
    for (int i = 0; i < 10; i++) step(1'b1, 5'd2, 32'(i + 7), 1'b1);
    check("pre_rst_retire", 64'(rc0), 64'd10);
    check("pre_rst_slot1", 64'(pr0[63:32]), 64'd16);
    #3 rst_n0 = 1'b0;
    #1;
    check("async_rst_counts", {cc0, rc0}, 64'd0);
    check("async_rst_state", {60'd0, st0, dn0, to0}, 64'd0);
    check("async_rst_regs", pr0[63:0], 64'd0);
    check("async_rst_written", 64'(pw0), 64'd0);
    #2 rst_n0 = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b1);
    check("resume_state", 64'(st0), 64'd1);
    check("resume_retire", 64'(rc0), 64'd1);
    rst_n0 = 1'b0;

    // ---- timeout (TIMEOUT_CYCLES=50) ----
    rst_n1 = 1'b1;
    waited = 0;
    while (waited < 60 && to1 !== 1'b1) begin
      step(1'b0, 5'd0, 32'h0, 1'b1);
      waited++;
    end
    check("to_latency", 64'(waited), 64'd50);
    check("to_counts", {cc1, rc1}, {32'd50, 32'd50});
    check("to_state", {60'd0, st1, dn1, to1}, {60'd0, 2'd3, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) step(1'b1, 5'd1, 32'hAB, 1'b1);
    check("to_frozen", {cc1, rc1}, {32'd50, 32'd50});
    check("to_frozen_slot0", 64'(pr1[31:0]), 64'd0);
    rst_n1 = 1'b0;

    // ---- simultaneous halt/timeout (IDLE_LIMIT=4, TIMEOUT_CYCLES=10) ----
    rst_n2 = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'h0, 1'b1);
    waited = 0;
    while (waited < 20 && st2 == 2'd1) begin
      step(1'b0, 5'd0, 32'h0, 1'b0);
      waited++;
    end
    check("tie_wait", 64'(waited), 64'd4);
    check("tie_state", {60'd0, st2, dn2, to2}, {60'd0, 2'd3, 1'b0, 1'b1});
    check("tie_counts", {cc2, rc2}, {32'd10, 32'd6});
    rst_n2 = 1'b0;

    // ---- parametrised window (NUM_PROBE=4, PROBE_BASE=10) ----
    rst_n3 = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b1, 5'd13, 32'hDEAD_BEEF, 1'b0);
    check("p_slot3", 64'(pr3[127:96]), 64'hDEAD_BEEF);
    step(1'b1, 5'd9, 32'h1111_1111, 1'b1);
    step(1'b1, 5'd14, 32'h2222_2222, 1'b0);
    check("p_ignore_hi", pr3[127:64], 64'hDEAD_BEEF_0000_0000);
    check("p_ignore_lo", pr3[63:0], 64'd0);
    check("p_written", 64'(pw3), 64'b1000);
    step(1'b1, 5'd10, 32'h0000_0005, 1'b1);
    check("p_slot0", 64'(pr3[31:0]), 64'd5);
    check("p_written2", 64'(pw3), 64'b1001);
    clr = 1'b1;
    step(1'b1, 5'd11, 32'h7777_7777, 1'b1);
    clr = 1'b0;
    check("p_clr_hi", pr3[127:64], 64'd0);
    check("p_clr_lo", pr3[63:0], 64'd0);
    check("p_clr_written", 64'(pw3), 64'd0);
    check("p_clr_state", {cc3, 28'd0, st3, dn3, to3}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_probe_monitor.md
Name: rf_probe_monitor

Overview:
- Synthesizable observation unit for the 5-stage RISC-V core; parametrised successor to the fixed six-register (x1..x6) debug outputs of DataPath.
- Snoops the register-file write-back port and holds shadow copies of a configurable window of architectural registers.
- Counts cycles and retired instructions, and detects program completion (retire idle) or runaway (cycle timeout) in hardware, so benches and FPGA builds stop on a flag instead of a fixed #delay.

Parameters:
- XLEN, 32, data width of registers and write-back data.
- NUM_PROBE, 6, number of shadowed registers (1..31).
- PROBE_BASE, 1, first shadowed register index; PROBE_BASE+NUM_PROBE-1 <= 31.
- IDLE_LIMIT, 16, consecutive non-retire cycles in RUN that declare HALTED.
- TIMEOUT_CYCLES, 1000, cycle count at which TIMEOUT is declared.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, same effect as reset.
- wb_we  in  1  register-file write enable from the WB stage.
- wb_rd  in  5  destination register index.
- wb_data  in  XLEN  write-back data.
- retire_valid  in  1  one instruction retired this cycle.
- probe_regs  out  NUM_PROBE*XLEN  shadow values; slot i occupies bits [i*XLEN +: XLEN] and maps to register PROBE_BASE+i.
- probe_written  out  NUM_PROBE  sticky per-slot flags: slot written since reset or clr.
- cycle_count  out  32  cycles spent in RUN.
- retire_count  out  32  retired instructions.
- mon_state  out  2  current FSM state.
- done  out  1  high in HALTED.
- timeout  out  1  high in TIMEOUT.

Behaviour:
- Reset or clr: all outputs 0, mon_state=IDLE. Reset is asynchronous assert, synchronous deassert handled upstream. clr has priority over every other input.
- FSM states: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
  - IDLE -> RUN on the first cycle with retire_valid=1. That cycle counts as cycle 1, retire 1.
  - RUN -> TIMEOUT when the next cycle_count value equals TIMEOUT_CYCLES.
  - RUN -> HALTED when the idle counter reaches IDLE_LIMIT.
  - If TIMEOUT and HALTED qualify in the same cycle, TIMEOUT wins.
  - HALTED and TIMEOUT are terminal. They are left only by reset or clr.
- Idle counter:
  - Cleared on every retire_valid cycle.
  - Increments on every RUN cycle without retire.
  - Saturates at IDLE_LIMIT.
- Other counters:
  - cycle_count increments every RUN cycle.
  - retire_count increments on retire_valid in IDLE or RUN.
  - Both saturate at 32'hFFFFFFFF and freeze in terminal states.
- Shadow capture:
  - Occurs when wb_we=1 and wb_rd is in [PROBE_BASE, PROBE_BASE+NUM_PROBE-1] and wb_rd != 0.
  - The write goes to slot wb_rd-PROBE_BASE. That slot's probe_written bit sets.
  - Latency: the new value is visible on probe_regs the cycle after the capturing edge. There is no combinational bypass.
  - Captures occur in IDLE and RUN. Shadows freeze in HALTED and TIMEOUT (a final-state snapshot).
  - Writes outside the window, or to x0, are ignored.
  - The retire_valid value on a write cycle does not affect capture.
- Back-to-back writes to the same register: the last write wins, one value per cycle.
- Reset mid-run: everything clears immediately (asynchronous). The block resumes in IDLE.
- done and timeout are registered decodes of mon_state and are mutually exclusive.

Decomposition:
- Shared package riscv_dbg_pkg:
  - MON_IDLE/MON_RUN/MON_HALTED/MON_TIMEOUT encodings.
  - REG_IDX_W=5.
  - Counter width constant CNT_W=32.
- Sub-module probe_slot (instantiated NUM_PROBE times via generate):
  - Parameters XLEN, REG_IDX.
  - Compares wb_rd against REG_IDX, holds the XLEN-bit shadow and the written flag, gated by a capture-enable from the FSM.

Test Plan:
- Window capture: defaults; after the first retire, write rd=3 data=32'h0000_00AA -> next cycle probe_regs slot 2 = 0xAA, probe_written=6'b000100. Write rd=0 and rd=9 -> no change.
- Idle halt: 20 consecutive retires, then retire_valid held 0 -> done=1 exactly 16 cycles after the last retire. mon_state=2, retire_count=20, cycle_count=36. A subsequent rd=1 write leaves the shadow unchanged.
- Timeout: TIMEOUT_CYCLES=50, retire every cycle -> timeout=1 when cycle_count=50, done=0. Counters frozen afterwards.
- Simultaneous: IDLE_LIMIT=4, TIMEOUT_CYCLES=10, retire cycles 1..6 then idle -> both conditions qualify at cycle 10. Expect timeout=1, done=0.
- Reset mid-run: reset low asynchronously between edges after 10 retires -> all outputs 0 before the next clk edge. Release, retire once -> mon_state=RUN, retire_count=1.
- Parametrisation: NUM_PROBE=4, PROBE_BASE=10. Write rd=13 data=0xDEADBEEF -> slot 3 = 0xDEADBEEF. Write rd=9 or rd=14 -> ignored. The clr pulse clears all slots.
